// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the clk_div_bank divider channels.
package clk_div_pkg;

    typedef enum logic [1:0] {
        CH_STOP = 2'b00,
        CH_RUN  = 2'b01,
        CH_PEND = 2'b10
    } ch_state_t;

    localparam int DEFAULT_HALF = 5;

endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration write handshake for clk_div_bank: valid/ready with channel select and half-period.
interface clk_div_bank_if #(
    parameter int NUM_CH = 2,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             cfg_valid;
    logic [CH_W-1:0]  cfg_ch;
    logic [CNT_W-1:0] cfg_half;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_half,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_half,
        output cfg_ready
    );

endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: STOP/RUN/PEND state machine, half-period counter and shadow register.
// Optional global resynchronisation input when CLK_DIV_BANK_SYNC_EN is defined.
module clk_div_ch #(
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic             sync,
`endif
    input  logic             wr,
    input  logic [CNT_W-1:0] wr_half,
    output logic             clk_lvl,
    output logic             tick,
    output logic             pend
);
    import clk_div_pkg::*;

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] RST_HALF  = CNT_W'(DEFAULT_HALF);
    localparam ch_state_t        RST_STATE = (DEFAULT_HALF == 0) ? CH_STOP : CH_RUN;

    ch_state_t        state_r,  state_s;
    logic [CNT_W-1:0] cnt_r,    cnt_s;
    logic [CNT_W-1:0] half_r,   half_s;
    logic [CNT_W-1:0] shadow_r, shadow_s;
    logic             lvl_r,    lvl_s;
    logic             tick_r,   tick_s;
    logic             at_bound_s;

    // State, counter, shadow and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= RST_STATE;
            cnt_r    <= CNT_ZERO;
            half_r   <= RST_HALF;
            shadow_r <= CNT_ZERO;
            lvl_r    <= 1'b0;
            tick_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            cnt_r    <= cnt_s;
            half_r   <= half_s;
            shadow_r <= shadow_s;
            lvl_r    <= lvl_s;
            tick_r   <= tick_s;
        end
    end

    // Next-state logic; the compare happens before increment so half=all-ones never wraps.
    always_comb begin
        state_s    = state_r;
        cnt_s      = cnt_r;
        half_s     = half_r;
        shadow_s   = shadow_r;
        lvl_s      = lvl_r;
        tick_s     = 1'b0;
        at_bound_s = (cnt_r == half_r);
`ifdef CLK_DIV_BANK_SYNC_EN
        if (sync && (state_r != CH_STOP)) begin
            cnt_s = CNT_ZERO;
            lvl_s = 1'b0;
            if (state_r == CH_PEND) begin
                half_s  = shadow_r;
                state_s = (shadow_r == CNT_ZERO) ? CH_STOP : CH_RUN;
            end else begin
                state_s = state_r;
            end
        end else if (sync) begin
            state_s = state_r;
        end else
`endif
        begin
            case (state_r)
                CH_STOP: begin
                    cnt_s = CNT_ZERO;
                    lvl_s = 1'b0;
                    if (wr) begin
                        half_s  = wr_half;
                        state_s = (wr_half != CNT_ZERO) ? CH_RUN : CH_STOP;
                    end else begin
                        state_s = CH_STOP;
                    end
                end
                CH_RUN: begin
                    if (wr) begin
                        shadow_s = wr_half;
                        state_s  = CH_PEND;
                    end else begin
                        state_s = CH_RUN;
                    end
                    if (en && at_bound_s) begin
                        cnt_s  = CNT_ZERO;
                        lvl_s  = ~lvl_r;
                        tick_s = ~lvl_r;
                    end else if (en) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                CH_PEND: begin
                    // Entering STOP forces the level low so no pulse is cut short.
                    if (en && at_bound_s) begin
                        cnt_s  = CNT_ZERO;
                        half_s = shadow_r;
                        if (shadow_r == CNT_ZERO) begin
                            state_s = CH_STOP;
                            lvl_s   = 1'b0;
                        end else begin
                            state_s = CH_RUN;
                            lvl_s   = ~lvl_r;
                            tick_s  = ~lvl_r;
                        end
                    end else if (en) begin
                        cnt_s = cnt_r + CNT_ONE;
                    end else begin
                        cnt_s = cnt_r;
                    end
                end
                default: begin
                    state_s = CH_STOP;
                    cnt_s   = CNT_ZERO;
                    lvl_s   = 1'b0;
                end
            endcase
        end
    end

    assign clk_lvl = lvl_r;
    assign tick    = tick_r;
    assign pend    = (state_r == CH_PEND);

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH independent 50%-duty clock dividers with a shared config write port.
// Define CLK_DIV_BANK_SYNC_EN to add the global sync input.
module clk_div_bank #(
    parameter int NUM_CH       = 2,
    parameter int CNT_W        = 8,
    parameter int DEFAULT_HALF = clk_div_pkg::DEFAULT_HALF
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              en,
`ifdef CLK_DIV_BANK_SYNC_EN
    input  logic              sync,
`endif
    clk_div_bank_if.slave     cfg,
    output logic [NUM_CH-1:0] clk_lvl,
    output logic [NUM_CH-1:0] tick
);
    import clk_div_pkg::*;

    logic [NUM_CH-1:0] pend_s;
    logic [NUM_CH-1:0] wr_s;
    logic              ready_s;

    // Ready drops only when the addressed, in-range channel holds a pending write.
    always_comb begin
        ready_s = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            ready_s = ready_s & ~((int'(cfg.cfg_ch) == i) & pend_s[i]);
        end
    end

    // Write decode; an out-of-range channel index matches no channel.
    always_comb begin
        wr_s = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            wr_s[i] = cfg.cfg_valid & ready_s & (int'(cfg.cfg_ch) == i);
        end
    end

    assign cfg.cfg_ready = ready_s;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_ch #(
            .CNT_W        (CNT_W),
            .DEFAULT_HALF (DEFAULT_HALF)
        ) u_ch (
            .clk     (CLK),
            .rst_n   (reset),
            .en      (en),
`ifdef CLK_DIV_BANK_SYNC_EN
            .sync    (sync),
`endif
            .wr      (wr_s[g]),
            .wr_half (cfg.cfg_half),
            .clk_lvl (clk_lvl[g]),
            .tick    (tick[g]),
            .pend    (pend_s[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (NUM_CH=2, CNT_W=8): table, directed corners, random vs model.
module tb_clk_div_bank;

    logic       CLK;
    logic       reset;
    logic       en;
    logic       sync;
    logic [1:0] clk_lvl;
    logic [1:0] tick;

    int n_tests = 0;
    int n_fail  = 0;

    clk_div_bank_if #(.NUM_CH(2), .CNT_W(8)) cfg_if ();

    clk_div_bank #(.NUM_CH(2), .CNT_W(8), .DEFAULT_HALF(5)) dut (
        .CLK     (CLK),
        .reset   (reset),
        .en      (en),
`ifdef CLK_DIV_BANK_SYNC_EN
        .sync    (sync),
`endif
        .cfg     (cfg_if.slave),
        .clk_lvl (clk_lvl),
        .tick    (tick)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Reference model: per channel, cycles remaining until the next boundary.
    bit m_stop [2];
    bit m_pend [2];
    int m_half [2];
    int m_shad [2];
    int m_left [2];
    bit m_lvl  [2];
    bit m_tick [2];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_stop[i] = 1'b0; m_pend[i] = 1'b0; m_half[i] = 5; m_shad[i] = 0;
            m_left[i] = 6;    m_lvl[i]  = 1'b0; m_tick[i] = 1'b0;
        end
    endtask

    task automatic model_edge(input bit e, input bit v, input int ch, input int h, input bit s);
        bit acc;
        acc = v && !m_pend[ch];
        for (int i = 0; i < 2; i++) begin
            bit wr;
            wr = acc && (ch == i) && !s;
            m_tick[i] = 1'b0;
            if (s && !m_stop[i]) begin
                m_lvl[i] = 1'b0;
                if (m_pend[i]) begin
                    m_half[i] = m_shad[i];
                    m_pend[i] = 1'b0;
                    if (m_half[i] == 0) m_stop[i] = 1'b1;
                end
                m_left[i] = m_half[i] + 1;
            end else if (s) begin
                m_lvl[i] = 1'b0;
            end else if (m_stop[i]) begin
                m_lvl[i] = 1'b0;
                if (wr) begin
                    m_half[i] = h;
                    if (h != 0) begin
                        m_stop[i] = 1'b0;
                        m_left[i] = h + 1;
                    end
                end
            end else begin
                if (e) begin
                    m_left[i]--;
                    if (m_left[i] == 0) begin
                        if (m_pend[i]) begin
                            m_half[i] = m_shad[i];
                            m_pend[i] = 1'b0;
                        end
                        if (m_half[i] == 0) begin
                            m_stop[i] = 1'b1;
                            m_lvl[i]  = 1'b0;
                        end else begin
                            m_lvl[i]  = !m_lvl[i];
                            m_tick[i] = m_lvl[i];
                            m_left[i] = m_half[i] + 1;
                        end
                    end
                end
                if (wr) begin
                    m_pend[i] = 1'b1;
                    m_shad[i] = h;
                end
            end
        end
    endtask

    // One clock cycle: drive at negedge, check ready, advance model, check outputs after the edge.
    task automatic step(input bit e, input bit v, input int ch, input int h, input bit s);
        @(negedge CLK);
        en               = e;
        cfg_if.cfg_valid = v;
        cfg_if.cfg_ch    = ch[0:0];
        cfg_if.cfg_half  = h[7:0];
        sync             = s;
        #1;
        chk("cfg_ready", {31'd0, cfg_if.cfg_ready}, {31'd0, !m_pend[ch]});
        model_edge(e, v, ch, h, s);
        @(posedge CLK);
        #1;
        chk("clk_lvl", {30'd0, clk_lvl}, {30'd0, m_lvl[1], m_lvl[0]});
        chk("tick",    {30'd0, tick},    {30'd0, m_tick[1], m_tick[0]});
        cfg_if.cfg_valid = 1'b0;
        sync             = 1'b0;
    endtask

    task automatic do_reset();
        en = 1'b0; cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = 1'b0; cfg_if.cfg_half = 8'd0; sync = 1'b0;
        #3;
        reset = 1'b0;
        #1;
        chk("rst_lvl",   {30'd0, clk_lvl}, 32'd0);
        chk("rst_tick",  {30'd0, tick},    32'd0);
        chk("rst_ready", {31'd0, cfg_if.cfg_ready}, 32'd1);
        model_reset();
        @(posedge CLK);
        #1;
        chk("rst_ready_hold", {31'd0, cfg_if.cfg_ready}, 32'd1);
        @(negedge CLK);
        reset = 1'b1;
    endtask

    typedef struct {
        logic       e;
        logic [1:0] lvl;
        logic [1:0] tk;
    } vec_t;

    vec_t tbl [18];

    initial begin
        int minrun;
        int run;
        logic prev;
        reset = 1'b0;

        // Post-reset waveform for both channels at the default half=5 (period 12).
        for (int k = 0; k < 18; k++) tbl[k] = '{e: 1'b1, lvl: 2'b00, tk: 2'b00};
        tbl[5]  = '{e: 1'b1, lvl: 2'b11, tk: 2'b11};
        tbl[6]  = '{e: 1'b1, lvl: 2'b11, tk: 2'b00};
        tbl[7]  = '{e: 1'b1, lvl: 2'b11, tk: 2'b00};
        tbl[8]  = '{e: 1'b1, lvl: 2'b11, tk: 2'b00};
        tbl[9]  = '{e: 1'b1, lvl: 2'b11, tk: 2'b00};
        tbl[10] = '{e: 1'b1, lvl: 2'b11, tk: 2'b00};
        tbl[17] = '{e: 1'b1, lvl: 2'b11, tk: 2'b11};

        do_reset();
        for (int k = 0; k < 18; k++) begin
            step(tbl[k].e, 1'b0, 0, 0, 1'b0);
            chk("tbl_lvl",  {30'd0, clk_lvl}, {30'd0, tbl[k].lvl});
            chk("tbl_tick", {30'd0, tick},    {30'd0, tbl[k].tk});
        end

        // Shadow write mid-phase: ready low until the boundary, then period 4.
        do_reset();
        step(1'b1, 1'b0, 1, 0, 1'b0);
        step(1'b1, 1'b0, 1, 0, 1'b0);
        step(1'b1, 1'b1, 1, 1, 1'b0);
        chk("pend_ready_low", {31'd0, cfg_if.cfg_ready}, 32'd0);
        step(1'b1, 1'b0, 1, 0, 1'b0);
        step(1'b1, 1'b0, 1, 0, 1'b0);
        step(1'b1, 1'b0, 1, 0, 1'b0);
        chk("pend_ready_back", {31'd0, cfg_if.cfg_ready}, 32'd1);
        chk("pend_rise",       {31'd0, clk_lvl[1]}, 32'd1);
        prev = clk_lvl[1]; run = 1; minrun = 1000;
        for (int k = 0; k < 12; k++) begin
            step(1'b1, 1'b0, 1, 0, 1'b0);
            if (clk_lvl[1] == prev) run++;
            else begin
                if (run < minrun) minrun = run;
                run = 1;
            end
            prev = clk_lvl[1];
            if (k == 3) chk("new_period_tick", {31'd0, tick[1]}, 32'd1);
        end
        chk("min_pulse", minrun, 2);

        // Stop via shadow, then restart from STOP.
        do_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("stop_lvl",    {31'd0, clk_lvl[0]}, 32'd0);
        chk("stop_notick", {30'd0, tick},       32'd2);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 2, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("restart_low",  {31'd0, clk_lvl[0]}, 32'd0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("restart_rise", {31'd0, clk_lvl[0]}, 32'd1);
        chk("restart_tick", {31'd0, tick[0]},    32'd1);

        // Freeze with en=0 mid-phase, then finish the remaining count.
        do_reset();
        for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b0, 0, 0, 1'b0);
            chk("freeze_lvl", {30'd0, clk_lvl}, 32'd0);
        end
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("resume_low",  {30'd0, clk_lvl}, 32'd0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("resume_rise", {30'd0, clk_lvl}, 32'd3);
        chk("resume_tick", {30'd0, tick},    32'd3);

        // Asynchronous reset while a write is pending.
        do_reset();
        for (int k = 0; k < 7; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 0, 1, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("pre_rst_high", {30'd0, clk_lvl}, 32'd3);
        do_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("lost_write", {31'd0, clk_lvl[0]}, 32'd0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("half_back_5", {30'd0, clk_lvl}, 32'd3);

`ifdef CLK_DIV_BANK_SYNC_EN
        // Sync aligns channels running at different phases.
        do_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1, 0, 1'b0);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b1, 1, 5, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b1);
        chk("sync_lvl",  {30'd0, clk_lvl}, 32'd0);
        chk("sync_tick", {30'd0, tick},    32'd0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'b0, 0, 0, 1'b0);
        step(1'b1, 1'b0, 0, 0, 1'b0);
        chk("sync_rise",  {30'd0, clk_lvl}, 32'd3);
        chk("sync_ticks", {30'd0, tick},    32'd3);
`endif

        // Randomised traffic against the model, including half=255 and a mid-run reset.
        do_reset();
        for (int k = 0; k < 3000; k++) begin
            bit e, v, s;
            int ch, h, r;
            e  = ($urandom_range(0, 9) != 0);
            v  = ($urandom_range(0, 3) == 0);
            ch = $urandom_range(0, 1);
            r  = $urandom_range(0, 19);
            h  = (r == 0) ? 0 : (r == 1) ? 255 : $urandom_range(1, 6);
`ifdef CLK_DIV_BANK_SYNC_EN
            s  = ($urandom_range(0, 49) == 0);
`else
            s  = 1'b0;
`endif
            step(e, v, ch, h, s);
            if (k == 1500) do_reset();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 The block SHALL have parameter NUM_CH, default 2: number of independent divider channels, 1..16.
REQ-002 The block SHALL have parameter CNT_W, default 8: half-period counter width.
REQ-003 The block SHALL have parameter DEFAULT_HALF, default 5: half-period value loaded by reset; 5 gives a divide-by-12 slow clock.
REQ-004 The block SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port en, input, 1 bit: global run enable.
REQ-007 The block SHALL have port cfg_valid, input, 1 bit: a configuration write is offered.
REQ-008 The block SHALL have port cfg_ch, input, max(1,$clog2(NUM_CH)) bits: the target channel.
REQ-009 The block SHALL have port cfg_half, input, CNT_W bits: the new half-period value; 0 means stop.
REQ-010 The block SHALL have port cfg_ready, output, 1 bit: the addressed channel can accept a write.
REQ-011 The block SHALL have port clk_lvl, output, NUM_CH bits: divided-clock levels, 50% duty.
REQ-012 The block SHALL have port tick, output, NUM_CH bits: one-cycle pulse per channel coinciding with each clk_lvl rise.

Function
REQ-013 Each channel SHALL be in one state of CH_STOP, CH_RUN or CH_PEND, and SHALL hold cnt (CNT_W bits) and half_reg.
REQ-014 In CH_RUN or CH_PEND with en=1, cnt SHALL increment each cycle; when cnt==half_reg, cnt SHALL go to 0 and clk_lvl SHALL toggle (a "boundary"); full period = 2*(half_reg+1) cycles.
REQ-015 tick[i] SHALL be registered, SHALL be 1 only in the cycle where clk_lvl[i] goes 0->1, and SHALL be 0 otherwise.
REQ-016 With en=0, cnt and clk_lvl SHALL freeze, tick SHALL be 0 and writes SHALL still be accepted.
REQ-017 cfg_ready SHALL be combinational and equal to 1 unless channel cfg_ch is in CH_PEND.
REQ-018 A write SHALL be accepted when cfg_valid && cfg_ready; an out-of-range cfg_ch SHALL be ignored.
REQ-019 A write to a CH_RUN channel SHALL store cfg_half in a shadow register and go to CH_PEND; it is applied at the next boundary: half_reg<=shadow, cnt<=0, state becomes CH_RUN, or CH_STOP if shadow==0.
REQ-020 On a boundary that enters CH_STOP, clk_lvl SHALL be forced 0 with no tick, so no pulse is ever shorter than min(old, new) half-period.
REQ-021 A write to a CH_STOP channel SHALL apply on the next cycle: half_reg<=cfg_half, cnt<=0, clk_lvl=0, and state becomes CH_RUN if cfg_half!=0.
REQ-022 In CH_STOP, cnt SHALL be 0, clk_lvl SHALL be 0 and tick SHALL be 0.
REQ-023 cnt SHALL never exceed half_reg, and half_reg = 2^CNT_W-1 SHALL be legal with no wrap glitch.
REQ-024 Channels SHALL be fully independent, and simultaneous boundaries on several channels SHALL be legal.

Reset
REQ-025 While reset=0, asynchronously: cnt=0, clk_lvl=0, tick=0, half_reg=DEFAULT_HALF, shadow=0, and state=CH_RUN (or CH_STOP if DEFAULT_HALF==0).
REQ-026 Reset mid-operation SHALL discard pending writes, and cfg_ready SHALL read 1 during and after reset.
REQ-027 After release, the first boundary SHALL occur DEFAULT_HALF+1 enabled cycles later.

Configuration
REQ-028 When CLK_DIV_BANK_SYNC_EN is defined, the block SHALL add input port sync (1 bit).
REQ-029 With that macro defined, sync=1 SHALL, on the next edge, clear cnt and clk_lvl of every non-stopped channel, apply every pending shadow immediately, and assert no tick; sync SHALL take priority over a same-cycle boundary or write.
REQ-030 When CLK_DIV_BANK_SYNC_EN is not defined, the sync port and its logic SHALL be absent, with behaviour as above.

Structure
REQ-031 Package clk_div_pkg SHALL hold the ch_state_t enum (CH_STOP, CH_RUN, CH_PEND) and the DEFAULT_HALF default constant.
REQ-032 Sub-module clk_div_ch SHALL implement one channel's state machine, counter and shadow, and SHALL be instantiated NUM_CH times via generate.
REQ-033 The top level SHALL hold only write decode and the cfg_ready multiplexer.

Verification (NUM_CH=2, CNT_W=8)
REQ-034 A bench SHALL check: reset released, en=1 -> clk_lvl[0] rises 6 cycles later; period 12; tick every 12 cycles, aligned with the rise.
REQ-035 A bench SHALL check: ch1 RUN half=5, write half=1 mid-phase -> cfg_ready low until the next boundary, then period 4; no level shorter than 2 cycles.
REQ-036 A bench SHALL check: write ch0 half=0 -> at the boundary clk_lvl[0]=0 with no tick; then write half=2 -> running next cycle, first rise 3 cycles later.
REQ-037 A bench SHALL check: en=0 for 10 cycles mid-phase -> cnt and clk_lvl frozen; resume completes the remaining count exactly.
REQ-038 A bench SHALL check: reset asserted asynchronously between edges while CH_PEND -> outputs 0 immediately; pending write lost; half back to 5.
REQ-039 A bench SHALL check, with the macro defined: sync=1 with channels at different phases -> both clk_lvl=0 and cnt=0 next cycle; subsequent rises coincide when halves match.
